riscv_core_div_sequencer: RTL and testbench
===========================================

Name: riscv_core_div_sequencer

Overview:
- Multi-cycle controller and datapath for the M-extension divide/remainder instructions: DIV, DIVU, REM, REMU and the W variants.
- Sits in the execute stage beside the ALU. Started when the decoder flags an M-extension op whose funct3[2]=1.
- Performs restoring division at one bit per cycle and asserts a stall request while running.
- Returns a single-cycle done pulse with the XLEN-wide result.

Parameters:
- XLEN, 64, datapath width. Word ops use the low 32 bits.

Ports:
- i_clk  input  1  core clock
- i_rst  input  1  synchronous, active-high reset
- i_div_start  input  1  request to begin an operation, sampled only in IDLE
- i_div_funct3  input  3  100 DIV, 101 DIVU, 110 REM, 111 REMU; funct3[2]=0 is ignored (no start)
- i_div_isword  input  1  1 = W variant (32-bit operation, sign-extended result)
- i_div_flush  input  1  kill the in-flight operation (pipeline flush)
- i_div_dividend  input  XLEN  rs1 value
- i_div_divisor  input  XLEN  rs2 value
- o_div_busy  output  1  high in PREP, CALC and FIX; used as the pipeline stall
- o_div_done  output  1  one-cycle pulse; o_div_result is valid in that cycle
- o_div_result  output  XLEN  quotient or remainder

Behaviour:
- Reset: state IDLE, counter 0, o_div_busy=0, o_div_done=0, o_div_result=0.
- All internal registers cleared by reset, including the cache under the optional feature.
- FSM states: IDLE, PREP, CALC, FIX, DONE.
- IDLE -> PREP when i_div_start=1, funct3[2]=1 and i_div_flush=0.
  - Latch operands, signed = ~funct3[0], want_rem = funct3[1], isword.
  - Width N = 32 if isword, otherwise XLEN.
- PREP (1 cycle):
  - For word ops, use operand bits [31:0].
  - Take absolute values when signed; record quotient sign = sa^sb and remainder sign = sa.
  - Divisor == 0: result = want_rem ? dividend : all-ones; go to DONE.
  - Signed overflow (dividend = most-negative N-bit value, divisor = -1): result = want_rem ? 0 : dividend; go to DONE.
  - Otherwise load counter = N-1 and go to CALC.
- CALC: each cycle shift {rem, quo} left by 1, trial-subtract the divisor, set the quotient LSB on non-negative. At counter == 0 go to FIX; otherwise decrement the counter.
- FIX (1 cycle): negate the quotient/remainder per the recorded signs, select by want_rem, then go to DONE.
- Special-case results and FIX results are both sign-extended from bit 31 when isword.
- DONE (1 cycle): o_div_done=1, o_div_result held; next state IDLE.
- o_div_result holds its value after DONE until the next DONE.
- Latency (start sampled in cycle 0):
  - Normal operation: DONE in cycle N+3 (67 for 64-bit, 35 for word).
  - Special cases: DONE in cycle 2.
- i_div_start outside IDLE is ignored and not queued.
- Back-to-back: a start in the DONE cycle is ignored; it is accepted in the following IDLE cycle.
- i_div_flush in any state: next state IDLE, no done pulse, result register unchanged.
- Flush and start in the same IDLE cycle: flush wins.
- Reset has priority over everything, including mid-CALC.
- Unsigned arithmetic throughout. The remainder register is N+1 bits wide for the trial subtract.

Optional Feature:
- Macro: RISCV_DIV_CACHE_EN.
- With the macro defined, one-entry operand cache:
  - Tag = {dividend, divisor, signed, isword}; data = final quotient and remainder (post-FIX, post-sign-extension). Special-case DONE also fills the cache.
  - The cache is written on every completed, non-flushed operation.
  - A start in IDLE whose tag matches the valid entry goes IDLE -> DONE directly, selecting quotient or remainder by want_rem. DONE occurs in cycle 1 and o_div_busy stays 0.
  - The valid bit is cleared only by reset. A flushed operation does not update the cache.
- Without the macro: no cache storage, and every start follows the full FSM path.

Test Plan:
- DIV 64-bit, dividend=100, divisor=-7 -> done in cycle 67, result = -14 (0xFFFF_FFFF_FFFF_FFF2); busy high cycles 1-66.
- REMU, dividend=0xFFFF_FFFF_FFFF_FFFF, divisor=10 -> result 5; then DIVUW, dividend=0x1_8000_0000, divisor=2 -> result 0x0000_0000_4000_0000, done in cycle 35.
- DIV by zero (dividend=42, divisor=0) -> result all-ones in cycle 2. REM by zero -> 42. DIV of 0x8000_0000_0000_0000 by -1 -> 0x8000_0000_0000_0000 in cycle 2. REMW overflow case -> 0.
- Start DIV, assert i_div_flush in cycle 20 -> IDLE in cycle 21, no done pulse, result unchanged; a start in cycle 22 completes normally. Reset mid-CALC -> all outputs 0 next cycle.
- Start held high through busy and DONE -> only one operation performed; the second is accepted in the IDLE cycle after DONE.
- Cache (with RISCV_DIV_CACHE_EN): DIV 100/7 (done, result 14), then REM 100/7 -> done in cycle 1 with result 2 and no busy. Without the macro, the same REM takes 67 cycles.

Source files
------------

// File: rtl/riscv_core_div_sequencer.sv
// riscv_core_div_sequencer
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU and their W variants.
// Resolves one quotient bit per cycle, holds o_div_busy as the execute-stage
// stall while running, and pulses o_div_done with the XLEN-wide result.
// Optional build macro RISCV_DIV_CACHE_EN adds a one-entry operand cache that
// answers a repeated operand pair straight from IDLE without stalling.

module riscv_core_div_sequencer #(
  parameter int XLEN = 64
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_div_start,
  input  logic [2:0]      i_div_funct3,
  input  logic            i_div_isword,
  input  logic            i_div_flush,
  input  logic [XLEN-1:0] i_div_dividend,
  input  logic [XLEN-1:0] i_div_divisor,
  output logic            o_div_busy,
  output logic            o_div_done,
  output logic [XLEN-1:0] o_div_result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_WORD = CW'(31);
  localparam logic [CW-1:0] CNT_FULL = CW'(XLEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  // Sign-extend from bit 31 for word ops, pass through otherwise.
  function automatic logic [XLEN-1:0] f_sext32(input logic [XLEN-1:0] v, input logic en);
    if (en) return {{(XLEN-32){v[31]}}, v[31:0]};
    return v;
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;

  // Operation context latched at start.
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic              r_signed;
  logic              r_want_rem;
  logic              r_isword;

  // Iteration datapath.
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_dvs;
  logic              r_neg_q;
  logic              r_neg_r;
  logic [CW-1:0]     r_cnt;
  logic [XLEN-1:0]   r_result;

  logic              w_accept;
  logic              w_sa;
  logic              w_sb;
  logic [31:0]       w_a_lo_abs;
  logic [31:0]       w_b_lo_abs;
  logic [XLEN-1:0]   w_a_full_abs;
  logic [XLEN-1:0]   w_b_full_abs;
  logic [XLEN-1:0]   w_quo_init;
  logic [XLEN-1:0]   w_dvs_init;
  logic [XLEN-1:0]   w_a_ext;
  logic              w_b_zero;
  logic              w_ovf;

  logic [XLEN:0]     w_trial;
  logic [XLEN:0]     w_diff;
  logic              w_fits;
  logic [XLEN-1:0]   w_rem_step;

  logic [XLEN-1:0]   w_q_sgn;
  logic [XLEN-1:0]   w_r_sgn;
  logic [XLEN-1:0]   w_fix_q;
  logic [XLEN-1:0]   w_fix_r;

  logic              w_fill;
  logic [XLEN-1:0]   w_fill_q;
  logic [XLEN-1:0]   w_fill_r;
  logic              w_res_load;
  logic [XLEN-1:0]   w_res_nxt;

`ifdef RISCV_DIV_CACHE_EN
  logic              r_c_valid;
  logic [XLEN-1:0]   r_c_a;
  logic [XLEN-1:0]   r_c_b;
  logic              r_c_signed;
  logic              r_c_isword;
  logic [XLEN-1:0]   r_c_q;
  logic [XLEN-1:0]   r_c_r;
  logic              w_cache_hit;

  assign w_cache_hit = r_c_valid
                    && (i_div_dividend == r_c_a)
                    && (i_div_divisor  == r_c_b)
                    && (~i_div_funct3[0] == r_c_signed)
                    && (i_div_isword == r_c_isword);
`endif

  assign w_accept = i_div_start & i_div_funct3[2] & ~i_div_flush;

  // Operand conditioning used during PREP: signs, magnitudes, special cases.
  assign w_sa = r_signed & (r_isword ? r_a[31] : r_a[XLEN-1]);
  assign w_sb = r_signed & (r_isword ? r_b[31] : r_b[XLEN-1]);

  assign w_a_lo_abs   = w_sa ? (32'd0 - r_a[31:0]) : r_a[31:0];
  assign w_b_lo_abs   = w_sb ? (32'd0 - r_b[31:0]) : r_b[31:0];
  assign w_a_full_abs = w_sa ? ({XLEN{1'b0}} - r_a) : r_a;
  assign w_b_full_abs = w_sb ? ({XLEN{1'b0}} - r_b) : r_b;

  // Word dividends are left-aligned so the MSB-first shift walks only bits
  // [31:0]; after 32 steps the quotient sits in the low half.
  assign w_quo_init = r_isword ? {w_a_lo_abs, {(XLEN-32){1'b0}}} : w_a_full_abs;
  assign w_dvs_init = r_isword ? {{(XLEN-32){1'b0}}, w_b_lo_abs} : w_b_full_abs;

  assign w_a_ext  = f_sext32(r_a, r_isword);
  assign w_b_zero = r_isword ? (r_b[31:0] == 32'd0) : (r_b == {XLEN{1'b0}});
  assign w_ovf    = r_signed && (r_isword
                    ? ((r_a[31:0] == 32'h8000_0000) && (r_b[31:0] == 32'hFFFF_FFFF))
                    : ((r_a == {1'b1, {(XLEN-1){1'b0}}}) && (r_b == {XLEN{1'b1}})));

  // One restoring step: the trial remainder is XLEN+1 bits so the borrow
  // out of the subtract tells whether the divisor fits.
  assign w_trial    = {r_rem, r_quo[XLEN-1]};
  assign w_diff     = w_trial - {1'b0, r_dvs};
  assign w_fits     = ~w_diff[XLEN];
  assign w_rem_step = w_fits ? w_diff[XLEN-1:0] : w_trial[XLEN-1:0];

  // Final sign correction applied in FIX.
  assign w_q_sgn = r_neg_q ? ({XLEN{1'b0}} - r_quo) : r_quo;
  assign w_r_sgn = r_neg_r ? ({XLEN{1'b0}} - r_rem) : r_rem;
  assign w_fix_q = f_sext32(w_q_sgn, r_isword);
  assign w_fix_r = f_sext32(w_r_sgn, r_isword);

  // Next-state, result-load and cache-fill decode.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    w_state_nxt = r_state;
    w_fill      = 1'b0;
    w_fill_q    = '0;
    w_fill_r    = '0;
    w_res_load  = 1'b0;
    w_res_nxt   = r_result;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_PREP;
`ifdef RISCV_DIV_CACHE_EN
          if (w_cache_hit) begin
            w_state_nxt = S_DONE;
            w_res_load  = 1'b1;
            w_res_nxt   = i_div_funct3[1] ? r_c_r : r_c_q;
          end
`endif
        end
      end
      S_PREP: begin
        if (w_b_zero) begin
          w_state_nxt = S_DONE;
          w_fill      = 1'b1;
          w_fill_q    = {XLEN{1'b1}};
          w_fill_r    = w_a_ext;
        end else if (w_ovf) begin
          w_state_nxt = S_DONE;
          w_fill      = 1'b1;
          w_fill_q    = w_a_ext;
          w_fill_r    = '0;
        end else begin
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        if (r_cnt == '0) w_state_nxt = S_FIX;
      end
      S_FIX: begin
        w_state_nxt = S_DONE;
        w_fill      = 1'b1;
        w_fill_q    = w_fix_q;
        w_fill_r    = w_fix_r;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_fill) begin
      w_res_load = 1'b1;
      w_res_nxt  = r_want_rem ? w_fill_r : w_fill_q;
    end

    // A flush kills whatever is in flight: no result, no cache update.
    if (i_div_flush) begin
      w_state_nxt = S_IDLE;
      w_fill      = 1'b0;
      w_res_load  = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Operand latch, iteration datapath, counter and result register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a        <= '0;
      r_b        <= '0;
      r_signed   <= 1'b0;
      r_want_rem <= 1'b0;
      r_isword   <= 1'b0;
      r_quo      <= '0;
      r_rem      <= '0;
      r_dvs      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_cnt      <= '0;
      r_result   <= '0;
    end else begin
      if ((r_state == S_IDLE) && w_accept) begin
        r_a        <= i_div_dividend;
        r_b        <= i_div_divisor;
        r_signed   <= ~i_div_funct3[0];
        r_want_rem <= i_div_funct3[1];
        r_isword   <= i_div_isword;
      end

      case (r_state)
        S_PREP: begin
          r_quo   <= w_quo_init;
          r_rem   <= '0;
          r_dvs   <= w_dvs_init;
          r_neg_q <= w_sa ^ w_sb;
          r_neg_r <= w_sa;
          r_cnt   <= r_isword ? CNT_WORD : CNT_FULL;
        end
        S_CALC: begin
          r_rem <= w_rem_step;
          r_quo <= {r_quo[XLEN-2:0], w_fits};
          if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
        end
        default: begin
        end
      endcase

      if (w_res_load) r_result <= w_res_nxt;
    end
  end

`ifdef RISCV_DIV_CACHE_EN
  // One-entry operand cache, refreshed by every completed operation.
  always_ff @(posedge i_clk) begin
    // NOTE: the payload is cleared along with the valid bit so reset leaves no unknown state behind.
    if (i_rst) begin
      r_c_valid  <= 1'b0;
      r_c_a      <= '0;
      r_c_b      <= '0;
      r_c_signed <= 1'b0;
      r_c_isword <= 1'b0;
      r_c_q      <= '0;
      r_c_r      <= '0;
    end else if (w_fill) begin
      r_c_valid  <= 1'b1;
      r_c_a      <= r_a;
      r_c_b      <= r_b;
      r_c_signed <= r_signed;
      r_c_isword <= r_isword;
      r_c_q      <= w_fill_q;
      r_c_r      <= w_fill_r;
    end
  end
`endif

  assign o_div_busy   = (r_state == S_PREP) || (r_state == S_CALC) || (r_state == S_FIX);
  assign o_div_done   = (r_state == S_DONE);
  assign o_div_result = r_result;

endmodule

// File: tb/tb_riscv_core_div_sequencer.sv
// tb_riscv_core_div_sequencer
// Randomized and directed bench for riscv_core_div_sequencer. Expected results
// come from plain integer division with the RISC-V special-case rules; expected
// latency comes from the documented cycle counts and a one-entry cache model
// (active when RISCV_DIV_CACHE_EN is defined).

module tb_riscv_core_div_sequencer;

  localparam int XLEN = 64;
`ifdef RISCV_DIV_CACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  localparam logic [2:0] F_DIV  = 3'b100;
  localparam logic [2:0] F_DIVU = 3'b101;
  localparam logic [2:0] F_REM  = 3'b110;
  localparam logic [2:0] F_REMU = 3'b111;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [2:0]      f3;
  logic            isw;
  logic            flush;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] res;

  always #5 clk = ~clk;

  riscv_core_div_sequencer #(.XLEN(XLEN)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_div_start    (start),
    .i_div_funct3   (f3),
    .i_div_isword   (isw),
    .i_div_flush    (flush),
    .i_div_dividend (a),
    .i_div_divisor  (b),
    .o_div_busy     (busy),
    .o_div_done     (done),
    .o_div_result   (res)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  // Reference model state.
  bit          m_valid;
  logic [63:0] m_a, m_b;
  bit          m_sgn, m_isw;
  logic [63:0] last_res;
  logic [63:0] last_a, last_b;
  logic [2:0]  last_f3;
  logic        last_isw;

  function automatic logic [63:0] ref_result(input logic [63:0] av, input logic [63:0] bv,
                                             input logic [2:0] f, input logic w);
    logic        sgn, want_rem;
    logic [31:0] a32, b32, r32;
    int          s_a32, s_b32;
    longint      s_a64, s_b64;
    logic [63:0] r64;
    sgn = ~f[0];
    want_rem = f[1];
    if (w) begin
      a32 = av[31:0];
      b32 = bv[31:0];
      s_a32 = a32;
      s_b32 = b32;
      if (b32 == 32'd0)                                              r32 = want_rem ? a32 : 32'hFFFF_FFFF;
      else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF)  r32 = want_rem ? 32'd0 : a32;
      else if (sgn)                                                  r32 = want_rem ? s_a32 % s_b32 : s_a32 / s_b32;
      else                                                           r32 = want_rem ? a32 % b32 : a32 / b32;
      return {{32{r32[31]}}, r32};
    end
    s_a64 = av;
    s_b64 = bv;
    if (bv == 64'd0)                                                           r64 = want_rem ? av : 64'hFFFF_FFFF_FFFF_FFFF;
    else if (sgn && av == 64'h8000_0000_0000_0000 && bv == 64'hFFFF_FFFF_FFFF_FFFF) r64 = want_rem ? 64'd0 : av;
    else if (sgn)                                                              r64 = want_rem ? s_a64 % s_b64 : s_a64 / s_b64;
    else                                                                       r64 = want_rem ? av % bv : av / bv;
    return r64;
  endfunction

  function automatic bit is_special(input logic [63:0] av, input logic [63:0] bv,
                                    input logic [2:0] f, input logic w);
    if (w) return (bv[31:0] == 32'd0) ||
                  (!f[0] && av[31:0] == 32'h8000_0000 && bv[31:0] == 32'hFFFF_FFFF);
    return (bv == 64'd0) ||
           (!f[0] && av == 64'h8000_0000_0000_0000 && bv == 64'hFFFF_FFFF_FFFF_FFFF);
  endfunction

  function automatic int exp_latency(input logic [63:0] av, input logic [63:0] bv,
                                     input logic [2:0] f, input logic w);
    if (CACHE_ON && m_valid && m_a == av && m_b == bv && m_sgn == !f[0] && m_isw == w) return 1;
    if (is_special(av, bv, f, w)) return 2;
    return w ? 35 : 67;
  endfunction

  function automatic void model_complete(input logic [63:0] av, input logic [63:0] bv,
                                         input logic [2:0] f, input logic w);
    m_valid  = 1'b1;
    m_a      = av;
    m_b      = bv;
    m_sgn    = !f[0];
    m_isw    = w;
    last_res = ref_result(av, bv, f, w);
    last_a   = av;
    last_b   = bv;
    last_f3  = f;
    last_isw = w;
  endfunction

  // Issue one operation (starting on the next negedge) and check it end to end.
  task automatic run_op(input string tag, input logic [63:0] av, input logic [63:0] bv,
                        input logic [2:0] f, input logic w);
    int          lat, cyc, done_cyc, busy_n;
    logic [63:0] exp, got;
    exp = ref_result(av, bv, f, w);
    lat = exp_latency(av, bv, f, w);
    @(negedge clk);
    a = av; b = bv; f3 = f; isw = w; start = 1'b1;
    cyc = 0; done_cyc = -1; busy_n = 0; got = '0;
    while (cyc < 200 && done_cyc < 0) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (busy) busy_n++;
      if (done) begin
        done_cyc = cyc;
        got = res;
      end
    end
    check({tag, ".lat"},  64'(done_cyc), 64'(lat));
    check({tag, ".res"},  got, exp);
    check({tag, ".busy"}, 64'(busy_n), 64'(lat - 1));
    @(negedge clk);
    check({tag, ".pulse"}, 64'(done), 64'd0);
    check({tag, ".hold"},  res, exp);
    model_complete(av, bv, f, w);
  endtask

  // Keep start high through the whole operation and into the next one.
  task automatic held_start(input logic [63:0] av, input logic [63:0] bv,
                            input logic [2:0] f, input logic w);
    int          lat1, lat2, n_done, d1, d2, last_cyc;
    logic [63:0] exp, r1, r2;
    exp  = ref_result(av, bv, f, w);
    lat1 = exp_latency(av, bv, f, w);
    model_complete(av, bv, f, w);
    lat2 = exp_latency(av, bv, f, w);
    @(negedge clk);
    a = av; b = bv; f3 = f; isw = w; start = 1'b1;
    n_done = 0; d1 = -1; d2 = -1; r1 = '0; r2 = '0;
    last_cyc = lat1 + lat2 + 3;
    for (int c = 1; c <= last_cyc; c++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        if (n_done == 1) begin d1 = c; r1 = res; end
        else if (n_done == 2) begin d2 = c; r2 = res; end
      end
      if (c == lat1 + 2) start = 1'b0;
    end
    check("held.n_done", 64'(n_done), 64'd2);
    check("held.d1",     64'(d1), 64'(lat1));
    check("held.d2",     64'(d2), 64'(lat1 + 1 + lat2));
    check("held.r1",     r1, exp);
    check("held.r2",     r2, exp);
    model_complete(av, bv, f, w);
  endtask

  initial begin
    logic [63:0] pa, pb, ra, rb, prev;
    logic        pw, rw;
    logic [2:0]  rf;
    bit          saw;
    int          cat;

    rst = 1'b1; start = 1'b0; flush = 1'b0; f3 = '0; isw = 1'b0; a = '0; b = '0;
    m_valid = 1'b0; last_res = '0;
    last_a = '0; last_b = '0; last_f3 = F_DIV; last_isw = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    check("rst.res",  res, 64'd0);
    rst = 1'b0;

    // Directed cases.
    run_op("div_neg",   64'd100, -64'sd7, F_DIV, 1'b0);
    run_op("remu_max",  64'hFFFF_FFFF_FFFF_FFFF, 64'd10, F_REMU, 1'b0);
    run_op("divuw",     64'h1_8000_0000, 64'd2, F_DIVU, 1'b1);
    run_op("div_by0",   64'd42, 64'd0, F_DIV, 1'b0);
    run_op("rem_by0",   64'd42, 64'd0, F_REM, 1'b0);
    run_op("div_ovf",   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, F_DIV, 1'b0);
    run_op("remw_ovf",  64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, F_REM, 1'b1);
    run_op("div_100_7", 64'd100, 64'd7, F_DIV, 1'b0);
    run_op("rem_100_7", 64'd100, 64'd7, F_REM, 1'b0);
    run_op("divw_neg",  64'hDEAD_BEEF_FFFF_FF9C, 64'h1234_5678_0000_0007, F_DIV, 1'b1);

    // Flush mid-CALC: back to IDLE, no pulse, result untouched.
    prev = last_res;
    @(negedge clk);
    a = 64'd123456789; b = 64'd97; f3 = F_DIV; isw = 1'b0; start = 1'b1;
    saw = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (done) saw = 1'b1;
      if (c == 20) flush = 1'b1;
      if (c == 21) begin
        check("flush.busy", 64'(busy), 64'd0);
        flush = 1'b0;
      end
    end
    check("flush.nodone", 64'(saw), 64'd0);
    check("flush.res",    res, prev);
    run_op("post_flush", 64'd123456789, 64'd97, F_DIV, 1'b0);

    // Flush and start together in IDLE: flush wins.
    @(negedge clk);
    a = 64'd500; b = 64'd3; f3 = F_DIVU; isw = 1'b0; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start.busy", 64'(busy), 64'd0);
    check("flush_start.done", 64'(done), 64'd0);

    // Reset mid-CALC clears all outputs and the cache.
    @(negedge clk);
    a = 64'hFEDC_BA98_7654_3210; b = 64'd12345; f3 = F_REMU; isw = 1'b0; start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check("midrst.busy", 64'(busy), 64'd0);
    check("midrst.done", 64'(done), 64'd0);
    check("midrst.res",  res, 64'd0);
    rst = 1'b0;
    m_valid = 1'b0;
    last_res = '0;
    run_op("post_rst", last_a, last_b, last_f3, last_isw);

    // Start held through busy and DONE.
    held_start(64'd1000, 64'd33, F_DIVU, 1'b0);

    // Randomized operations.
    pa = last_a; pb = last_b; pw = last_isw;
    for (int i = 0; i < 40; i++) begin
      rw = 1'($urandom_range(0, 1));
      rf = {1'b1, 2'($urandom_range(0, 3))};
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      cat = $urandom_range(0, 9);
      case (cat)
        0: rb = rw ? {rb[63:32], 32'h0} : 64'd0;
        1: begin
          ra = rw ? {ra[63:32], 32'h8000_0000} : 64'h8000_0000_0000_0000;
          rb = rw ? {rb[63:32], 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
        end
        2: begin ra = pa; rb = pb; rw = pw; end
        3: begin
          ra = 64'($urandom_range(0, 1000));
          rb = 64'($urandom_range(1, 20));
          if ($urandom_range(0, 1) == 1) rb = -rb;
        end
        4: rb = rb >> $urandom_range(1, 60);
        default: begin end
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op($sformatf("rnd%0d", i), ra, rb, rf, rw);
      pa = ra; pb = rb; pw = rw;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
